// File: rtl/mem_stage_if.sv
// EXE -> MEM pipeline bus: control/data from the EXE register plus the
// pass-throughs, load result and stall handshake coming back.
interface mem_stage_if;
    logic [31:0] ALU_res;
    logic [31:0] val_Rm;
    logic [3:0]  dst;
    logic        mem_read;
    logic        mem_write;
    logic        WB_en;
    logic [31:0] ALU_res_out;
    logic [31:0] mem_result;
    logic [3:0]  dst_out;
    logic        mem_read_out;
    logic        WB_en_out;
    logic        ready;

    modport master (
        output ALU_res, val_Rm, dst, mem_read, mem_write, WB_en,
        input  ALU_res_out, mem_result, dst_out, mem_read_out, WB_en_out, ready
    );

    modport slave (
        input  ALU_res, val_Rm, dst, mem_read, mem_write, WB_en,
        output ALU_res_out, mem_result, dst_out, mem_read_out, WB_en_out, ready
    );
endinterface

// File: rtl/mem_stage.sv
// Multi-cycle data-memory stage: every load/store stalls upstream for
// 1+WAIT_CYCLES cycles, then commits on the ACCESS->DONE edge.
module mem_stage #(
    parameter int WAIT_CYCLES = 4,
    parameter int MEM_DEPTH   = 64
) (
    input  logic        clk,
    input  logic        rst,
    mem_stage_if.slave  bus
);
    localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic [31:0] mem [MEM_DEPTH];
    logic [31:0] mem_result_q;

    logic          req;
    logic          do_write;
    logic          last;
    logic [31:0]   word_off;
    logic [AW-1:0] idx;

    // Read wins when both strobes are set, so the write is suppressed.
    assign req      = bus.mem_read | bus.mem_write;
    assign do_write = bus.mem_write & ~bus.mem_read;
    assign last     = (cnt == 4'(WAIT_CYCLES - 1));
    assign word_off = (bus.ALU_res - 32'd1024) >> 2;
    assign idx      = AW'(word_off % 32'(MEM_DEPTH));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            cnt          <= 4'd0;
            mem_result_q <= 32'd0;
            for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        state <= ACCESS;
                        cnt   <= 4'd0;
                    end
                end
                ACCESS: begin
                    cnt <= cnt + 4'd1;
                    // Upstream is frozen, so the address is still the one seen in IDLE.
                    if (last) begin
                        state <= DONE;
                        if (do_write)     mem[idx]     <= bus.val_Rm;
                        if (bus.mem_read) mem_result_q <= mem[idx];
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.ready        = !((state == ACCESS) || (state == IDLE && req));
    assign bus.mem_result   = mem_result_q;
    assign bus.ALU_res_out  = bus.ALU_res;
    assign bus.dst_out      = bus.dst;
    assign bus.mem_read_out = bus.mem_read;
    assign bus.WB_en_out    = bus.WB_en;
endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: stall length, load data, wrap, rd+wr priority,
// and reset during an access.
module tb_mem_stage;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    mem_stage_if bus ();

    mem_stage #(.WAIT_CYCLES(4), .MEM_DEPTH(64)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic        rd;
        logic        wr;
        int          exp_stall;
        logic [31:0] exp_res;
        string       name;
    } vec_t;

    vec_t vecs [11];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Counts cycles with ready low; entered just after a rising edge.
    task automatic measure(output int st);
        st = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (bus.ready === 1'b1) return;
            st++;
            @(posedge clk);
            #1;
        end
        errors++;
        $display("FAIL stall_timeout: ready still low after %0d cycles", st);
    endtask

    task automatic apply(input logic [31:0] a, input logic [31:0] d, input logic rd,
                         input logic wr, input int exp_stall, input logic [31:0] exp_res,
                         input bit hold_chk, input string nm);
        int st;
        bus.ALU_res   = a;
        bus.val_Rm    = d;
        bus.mem_read  = rd;
        bus.mem_write = wr;
        bus.dst       = a[5:2];
        bus.WB_en     = rd;
        #1;
        check({nm, "_passthru"},
              {26'd0, bus.ALU_res_out, bus.dst_out, bus.mem_read_out, bus.WB_en_out},
              {26'd0, a, a[5:2], rd, rd});
        measure(st);
        check({nm, "_stall"}, 64'(st), 64'(exp_stall));
        check({nm, "_result"}, {32'd0, bus.mem_result}, {32'd0, exp_res});
        @(posedge clk);
        #1;
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        if (hold_chk) begin
            @(negedge clk);
            check({nm, "_hold"}, {31'd0, bus.ready, bus.mem_result}, {31'd0, 1'b1, exp_res});
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int st;
        vecs[0]  = '{32'd1028, 32'h0,        1'b0, 1'b0, 0, 32'h0,        "idle"};
        vecs[1]  = '{32'd1028, 32'hDEADBEEF, 1'b0, 1'b1, 5, 32'h0,        "st_1028"};
        vecs[2]  = '{32'd1028, 32'h0,        1'b1, 1'b0, 5, 32'hDEADBEEF, "ld_1028"};
        vecs[3]  = '{32'd1032, 32'h5,        1'b1, 1'b1, 5, 32'h0,        "rdwr_1032"};
        vecs[4]  = '{32'd1032, 32'h0,        1'b1, 1'b0, 5, 32'h0,        "ld_1032"};
        vecs[5]  = '{32'd1280, 32'hCAFEF00D, 1'b0, 1'b1, 5, 32'h0,        "st_1280"};
        vecs[6]  = '{32'd1024, 32'h0,        1'b1, 1'b0, 5, 32'hCAFEF00D, "ld_1024_wrap"};
        vecs[7]  = '{32'd1028, 32'h0,        1'b1, 1'b0, 5, 32'hDEADBEEF, "ld_1028_again"};
        vecs[8]  = '{32'd1020, 32'h11111111, 1'b0, 1'b1, 5, 32'hDEADBEEF, "st_1020_under"};
        vecs[9]  = '{32'd1276, 32'h0,        1'b1, 1'b0, 5, 32'h11111111, "ld_1276"};
        vecs[10] = '{32'd1100, 32'h0,        1'b0, 1'b0, 0, 32'h11111111, "idle_hold"};

        // Reset state and pass-through during reset.
        bus.ALU_res = 32'h0000_1234; bus.val_Rm = 32'h0; bus.dst = 4'hA;
        bus.mem_read = 1'b0; bus.mem_write = 1'b0; bus.WB_en = 1'b1;
        #12;
        check("reset_state", {31'd0, bus.ready, bus.mem_result}, {31'd0, 1'b1, 32'h0});
        check("reset_passthru",
              {26'd0, bus.ALU_res_out, bus.dst_out, bus.mem_read_out, bus.WB_en_out},
              {26'd0, 32'h0000_1234, 4'hA, 1'b0, 1'b1});
        bus.mem_read = 1'b1;
        #1;
        check("reset_ready_req", {63'd0, bus.ready}, 64'd0);
        bus.mem_read = 1'b0;
        @(negedge clk);
        rst = 1'b1;

        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("idle_after_reset", {31'd0, bus.ready, bus.mem_result}, {31'd0, 1'b1, 32'h0});
        end
        @(posedge clk);
        #1;

        for (int i = 0; i < 11; i++)
            apply(vecs[i].addr, vecs[i].data, vecs[i].rd, vecs[i].wr,
                  vecs[i].exp_stall, vecs[i].exp_res, 1'b1, vecs[i].name);

        // Reset in the second ACCESS cycle of a store; request stays asserted.
        bus.ALU_res = 32'd1036; bus.val_Rm = 32'h1234; bus.dst = 4'h3;
        bus.mem_read = 1'b0; bus.mem_write = 1'b1; bus.WB_en = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("midrst_state", {31'd0, bus.ready, bus.mem_result}, {31'd0, 1'b0, 32'h0});
        #1;
        rst = 1'b1;
        measure(st);
        check("midrst_restall", 64'(st), 64'd5);
        check("midrst_result", {32'd0, bus.mem_result}, 64'd0);
        @(posedge clk);
        #1;
        // Back-to-back: load issued in the cycle right after DONE.
        apply(32'd1036, 32'h0, 1'b1, 1'b0, 5, 32'h1234, 1'b0, "ld_1036_b2b");
        apply(32'd1028, 32'h0, 1'b1, 1'b0, 5, 32'h0,    1'b1, "ld_1028_cleared");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
